// File: rtl/mem_ctrl.sv
// Line-granular memory controller: splits each cache-line read/write into
// single-outstanding beats on a valid/ready host bus and gathers read beats.
module mem_ctrl #(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned BEAT_W = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mem_op,
    input  logic [63:0]             cpu_addr,
    input  logic [BEATS*BEAT_W-1:0] wr_line,
    output logic                    ready,
    output logic                    tx_done,
    output logic [BEATS*BEAT_W-1:0] rd_line,
    output logic                    host_req_vld,
    input  logic                    host_req_rdy,
    output logic                    host_req_we,
    output logic [63:0]             host_req_addr,
    output logic [BEAT_W-1:0]       host_req_wdata,
    input  logic                    host_rsp_vld,
    input  logic [BEAT_W-1:0]       host_rsp_data
);
    localparam int unsigned      LINE_W     = BEATS * BEAT_W;
    localparam int unsigned      OFF_W      = $clog2(LINE_W / 8);
    localparam int unsigned      CNT_W      = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [63:0]      BEAT_BYTES = 64'(BEAT_W / 8);
    localparam logic [63:0]      LINE_MASK  = ~((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [63:0]        base_q, base_d;
    logic [LINE_W-1:0]  wr_q, wr_d;
    logic [LINE_W-1:0]  rd_q, rd_d;
    logic [31:0]        slot;
    logic [63:0]        beat_addr;
    logic               last_beat;

    assign slot      = 32'(beat_q) * BEAT_W;
    assign beat_addr = base_q + 64'(beat_q) * BEAT_BYTES;
    assign last_beat = (beat_q == LAST_BEAT);
    assign rd_line   = rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Request fields are pure functions of registered state, so they stay
    // stable for as long as the host holds off host_req_rdy.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        base_d         = base_q;
        wr_d           = wr_q;
        rd_d           = rd_q;
        ready          = 1'b0;
        tx_done        = 1'b0;
        host_req_vld   = 1'b0;
        host_req_we    = 1'b0;
        host_req_addr  = '0;
        host_req_wdata = '0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (mem_op[0]) begin
                    base_d = cpu_addr & LINE_MASK;
                    beat_d = '0;
                    if (mem_op[1]) begin
                        wr_d    = wr_line;
                        state_d = S_WR_REQ;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                host_req_vld  = 1'b1;
                host_req_addr = beat_addr;
                if (host_req_rdy) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (host_rsp_vld) begin
                    rd_d[slot +: BEAT_W] = host_rsp_data;
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + CNT_W'(1);
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                host_req_vld   = 1'b1;
                host_req_we    = 1'b1;
                host_req_addr  = beat_addr;
                host_req_wdata = wr_q[slot +: BEAT_W];
                if (host_req_rdy) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                tx_done = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
